// File: rtl/coll_scan_engine.sv
// Table-driven collision scanner: one object per clock against Pac-Man and ghost sprites.
// Optional `COLL_EDGE_EN adds new_hit_pac/new_hit_ghost rising-hit outputs.
module coll_scan_engine #(
    parameter int unsigned N_OBJ   = 48,
    parameter int unsigned IDX_W   = 6,
    parameter int unsigned COORD_W = 11,
    parameter int unsigned SPRITE  = 50
) (
    input  logic               collClk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] x_ghost,
    input  logic [COORD_W-1:0] y_ghost,
    input  logic [N_OBJ-1:0]   obj_en,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [COORD_W-1:0] cfg_x0,
    input  logic [COORD_W-1:0] cfg_y0,
    input  logic [COORD_W-1:0] cfg_x1,
    input  logic [COORD_W-1:0] cfg_y1,
    output logic               busy,
    output logic               done,
    output logic [N_OBJ-1:0]   hit_pac,
    output logic [N_OBJ-1:0]   hit_ghost,
    output logic               player_hit
`ifdef COLL_EDGE_EN
    ,
    output logic [N_OBJ-1:0]   new_hit_pac,
    output logic [N_OBJ-1:0]   new_hit_ghost
`endif
);

    localparam logic [COORD_W:0] SPR       = (COORD_W+1)'(SPRITE);
    localparam logic [IDX_W:0]   N_OBJ_LIM = (IDX_W+1)'(N_OBJ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_OBJ - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e r_state, w_state_nxt;

    logic [COORD_W-1:0] r_tx0 [N_OBJ];
    logic [COORD_W-1:0] r_ty0 [N_OBJ];
    logic [COORD_W-1:0] r_tx1 [N_OBJ];
    logic [COORD_W-1:0] r_ty1 [N_OBJ];

    logic [IDX_W-1:0]   r_idx;
    logic [COORD_W-1:0] r_px, r_py, r_gx, r_gy;
    logic [N_OBJ-1:0]   r_en;
    logic [N_OBJ-1:0]   r_sh_pac, r_sh_ghost;
    logic [N_OBJ-1:0]   r_hit_pac, r_hit_ghost;
    logic               r_player_hit;
`ifdef COLL_EDGE_EN
    logic [N_OBJ-1:0]   r_prev_pac, r_prev_ghost;
`endif

    logic               w_cfg_wr, w_last, w_hit_p, w_hit_g, w_ph;
    logic [N_OBJ-1:0]   w_sh_pac_nxt, w_sh_ghost_nxt;

    // Sprite [px,px+S) x [py,py+S) against rectangle [x0,x1) x [y0,y1); sums widened by one bit.
    function automatic logic f_overlap(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                       input logic [COORD_W-1:0] x0, input logic [COORD_W-1:0] y0,
                                       input logic [COORD_W-1:0] x1, input logic [COORD_W-1:0] y1);
        logic [COORD_W:0] w_pxe, w_pye;
        w_pxe = {1'b0, px} + SPR;
        w_pye = {1'b0, py} + SPR;
        return (px < x1) && ({1'b0, x0} < w_pxe) && (py < y1) && ({1'b0, y0} < w_pye) &&
               (x1 > x0) && (y1 > y0);
    endfunction

    function automatic logic f_sq_overlap(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                          input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
        return ({1'b0, ax} < {1'b0, bx} + SPR) && ({1'b0, bx} < {1'b0, ax} + SPR) &&
               ({1'b0, ay} < {1'b0, by} + SPR) && ({1'b0, by} < {1'b0, ay} + SPR);
    endfunction

    always_comb begin
        w_cfg_wr = cfg_we && (r_state == StIdle) && ({1'b0, cfg_idx} < N_OBJ_LIM);
        w_last   = (r_idx == LAST_IDX);
        w_hit_p  = f_overlap(r_px, r_py, r_tx0[r_idx], r_ty0[r_idx], r_tx1[r_idx], r_ty1[r_idx]);
        w_hit_g  = f_overlap(r_gx, r_gy, r_tx0[r_idx], r_ty0[r_idx], r_tx1[r_idx], r_ty1[r_idx]);
        w_ph     = f_sq_overlap(r_px, r_py, r_gx, r_gy);
        w_sh_pac_nxt          = r_sh_pac;
        w_sh_ghost_nxt        = r_sh_ghost;
        w_sh_pac_nxt[r_idx]   = w_hit_p & r_en[r_idx];
        w_sh_ghost_nxt[r_idx] = w_hit_g & r_en[r_idx];
    end

    always_ff @(posedge collClk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            StIdle: if (start) w_state_nxt = StScan;
            StScan: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = StDone;
            end
            StDone: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge collClk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_OBJ); i++) begin
                r_tx0[i] <= '0;
                r_ty0[i] <= '0;
                r_tx1[i] <= '0;
                r_ty1[i] <= '0;
            end
            r_idx        <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_gx         <= '0;
            r_gy         <= '0;
            r_en         <= '0;
            r_sh_pac     <= '0;
            r_sh_ghost   <= '0;
            r_hit_pac    <= '0;
            r_hit_ghost  <= '0;
            r_player_hit <= 1'b0;
`ifdef COLL_EDGE_EN
            r_prev_pac   <= '0;
            r_prev_ghost <= '0;
`endif
        end else begin
            if (w_cfg_wr) begin
                r_tx0[cfg_idx] <= cfg_x0;
                r_ty0[cfg_idx] <= cfg_y0;
                r_tx1[cfg_idx] <= cfg_x1;
                r_ty1[cfg_idx] <= cfg_y1;
            end
            if (r_state == StIdle && start) begin
                r_px       <= x;
                r_py       <= y;
                r_gx       <= x_ghost;
                r_gy       <= y_ghost;
                r_en       <= obj_en;
                r_sh_pac   <= '0;
                r_sh_ghost <= '0;
                r_idx      <= '0;
            end else if (r_state == StScan) begin
                r_sh_pac   <= w_sh_pac_nxt;
                r_sh_ghost <= w_sh_ghost_nxt;
                if (w_last) begin
                    // Publish on entry to DONE so results are valid alongside the done pulse.
                    r_hit_pac    <= w_sh_pac_nxt;
                    r_hit_ghost  <= w_sh_ghost_nxt;
                    r_player_hit <= w_ph;
`ifdef COLL_EDGE_EN
                    r_prev_pac   <= r_hit_pac;
                    r_prev_ghost <= r_hit_ghost;
`endif
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign hit_pac    = r_hit_pac;
    assign hit_ghost  = r_hit_ghost;
    assign player_hit = r_player_hit;

`ifdef COLL_EDGE_EN
    always_comb begin
        new_hit_pac   = '0;
        new_hit_ghost = '0;
        if (r_state == StDone) begin
            new_hit_pac   = r_hit_pac & ~r_prev_pac;
            new_hit_ghost = r_hit_ghost & ~r_prev_ghost;
        end
    end
`endif

endmodule

// File: tb/tb_coll_scan_engine.sv
// Scoreboard bench for coll_scan_engine: stimulus pushes expected results, a monitor checks on done.
// Define COLL_EDGE_EN to also check the new-hit outputs.
module tb_coll_scan_engine;

    localparam int N = 48;
    localparam logic [N-1:0] B0  = 48'h0000_0000_0001;
    localparam logic [N-1:0] B1  = 48'h0000_0000_0002;
    localparam logic [N-1:0] B47 = 48'h8000_0000_0000;
    localparam logic [N-1:0] ALL = {N{1'b1}};

    typedef struct packed {
        logic [N-1:0] pac;
        logic [N-1:0] ghost;
        logic [N-1:0] npac;
        logic [N-1:0] nghost;
        logic         ph;
    } exp_t;

    logic          collClk = 1'b0;
    logic          rst, start, cfg_we;
    logic [10:0]   x, y, x_ghost, y_ghost, cfg_x0, cfg_y0, cfg_x1, cfg_y1;
    logic [N-1:0]  obj_en;
    logic [5:0]    cfg_idx;
    logic          busy, done, player_hit;
    logic [N-1:0]  hit_pac, hit_ghost;
`ifdef COLL_EDGE_EN
    logic [N-1:0]  new_hit_pac, new_hit_ghost;
`endif

    exp_t          sb[$];
    logic [N-1:0]  prev_pac, prev_ghost;
    int            n_checks = 0;
    int            n_fail = 0;
    int            lat;

    coll_scan_engine dut (
        .collClk    (collClk),
        .rst        (rst),
        .start      (start),
        .x          (x),
        .y          (y),
        .x_ghost    (x_ghost),
        .y_ghost    (y_ghost),
        .obj_en     (obj_en),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_x0     (cfg_x0),
        .cfg_y0     (cfg_y0),
        .cfg_x1     (cfg_x1),
        .cfg_y1     (cfg_y1),
        .busy       (busy),
        .done       (done),
        .hit_pac    (hit_pac),
        .hit_ghost  (hit_ghost),
        .player_hit (player_hit)
`ifdef COLL_EDGE_EN
        ,
        .new_hit_pac   (new_hit_pac),
        .new_hit_ghost (new_hit_ghost)
`endif
    );

    always #5 collClk = ~collClk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge collClk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hit_pac", 64'(hit_pac), 64'(e.pac));
                chk("hit_ghost", 64'(hit_ghost), 64'(e.ghost));
                chk("player_hit", 64'(player_hit), 64'(e.ph));
`ifdef COLL_EDGE_EN
                chk("new_hit_pac", 64'(new_hit_pac), 64'(e.npac));
                chk("new_hit_ghost", 64'(new_hit_ghost), 64'(e.nghost));
`endif
            end
        end
`ifdef COLL_EDGE_EN
        if (!rst && busy && !done)
            chk("new_hit_idle", 64'(new_hit_pac | new_hit_ghost), 64'd0);
`endif
    end

    task automatic push_exp(input logic [N-1:0] ep, input logic [N-1:0] eg, input logic eph);
        exp_t e;
        e.pac    = ep;
        e.ghost  = eg;
        e.ph     = eph;
        e.npac   = ep & ~prev_pac;
        e.nghost = eg & ~prev_ghost;
        prev_pac   = ep;
        prev_ghost = eg;
        sb.push_back(e);
    endtask

    task automatic write_entry(input logic [5:0] idx, input logic [10:0] x0, input logic [10:0] y0,
                               input logic [10:0] x1, input logic [10:0] y1);
        cfg_we = 1'b1; cfg_idx = idx;
        cfg_x0 = x0; cfg_y0 = y0; cfg_x1 = x1; cfg_y1 = y1;
        @(posedge collClk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_pos(input logic [10:0] px, input logic [10:0] py,
                           input logic [10:0] gx, input logic [10:0] gy, input logic [N-1:0] en);
        x = px; y = py; x_ghost = gx; y_ghost = gy; obj_en = en;
    endtask

    task automatic wait_done();
        while (!done && lat < 200) begin
            @(posedge collClk); #1;
            lat++;
        end
        chk("done_latency", 64'(lat), 64'(N));
    endtask

    task automatic run_scan(input logic [10:0] px, input logic [10:0] py,
                            input logic [10:0] gx, input logic [10:0] gy, input logic [N-1:0] en,
                            input logic [N-1:0] ep, input logic [N-1:0] eg, input logic eph);
        push_exp(ep, eg, eph);
        set_pos(px, py, gx, gy, en);
        start = 1'b1;
        @(posedge collClk); #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        lat = 0;
        wait_done();
        @(posedge collClk); #1;
        chk("busy_after_done", 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0;
        cfg_x0 = '0; cfg_y0 = '0; cfg_x1 = '0; cfg_y1 = '0;
        set_pos(0, 0, 0, 0, '0);
        prev_pac = '0; prev_ghost = '0;
        repeat (3) @(posedge collClk);
        #1 rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hit_pac", 64'(hit_pac), 64'd0);
        chk("rst_hit_ghost", 64'(hit_ghost), 64'd0);
        chk("rst_player_hit", 64'(player_hit), 64'd0);

        write_entry(6'd0, 11'd310, 11'd25, 11'd330, 11'd65);
        write_entry(6'd47, 11'd1000, 11'd1000, 11'd1100, 11'd1100);

        run_scan(270, 20, 1000, 1000, B0 | B47, B0, B47, 1'b0);
        run_scan(260, 20, 1000, 1000, B0 | B47, '0, B47, 1'b0);   // edge touch
        run_scan(270, 20, 1000, 1000, '0, '0, '0, 1'b0);          // masked by enable
        run_scan(300, 60, 320, 40, B0, B0, B0, 1'b1);
        run_scan(300, 60, 400, 200, B0, B0, '0, 1'b0);

        // Mid-scan start, write and input change must all be ignored.
        push_exp(B0, B47, 1'b0);
        set_pos(270, 20, 1000, 1000, ALL);
        start = 1'b1;
        @(posedge collClk); #1;
        start = 1'b0;
        repeat (9) @(posedge collClk);
        #1;
        start = 1'b1; x = 11'd0; cfg_we = 1'b1; cfg_idx = 6'd1;
        cfg_x0 = 11'd0; cfg_y0 = 11'd0; cfg_x1 = 11'd2000; cfg_y1 = 11'd2000;
        @(posedge collClk); #1;
        start = 1'b0; cfg_we = 1'b0;
        lat = 10;
        wait_done();
        repeat (60) @(posedge collClk);
        #1 chk("busy_idle_after_ignored", 64'(busy), 64'd0);
        run_scan(0, 0, 1000, 1000, B1, '0, '0, 1'b0);              // entry 1 still zero

        // Reset mid-scan: no done pulse, outputs and table cleared.
        run_scan(300, 60, 320, 40, B0, B0, B0, 1'b1);
        set_pos(270, 20, 1000, 1000, B0);
        start = 1'b1;
        @(posedge collClk); #1;
        start = 1'b0;
        repeat (19) @(posedge collClk);
        #1 rst = 1'b1;
        @(posedge collClk); #1;
        rst = 1'b0;
        prev_pac = '0; prev_ghost = '0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hit_pac", 64'(hit_pac), 64'd0);
        chk("abort_hit_ghost", 64'(hit_ghost), 64'd0);
        chk("abort_player_hit", 64'(player_hit), 64'd0);
        repeat (60) @(posedge collClk);
        #1;
        run_scan(270, 20, 1000, 1000, ALL, '0, '0, 1'b0);

        // Repeated and returning hits exercise the new-hit history.
        write_entry(6'd0, 11'd310, 11'd25, 11'd330, 11'd65);
        run_scan(270, 20, 1000, 1000, B0, B0, '0, 1'b0);
        run_scan(270, 20, 1000, 1000, B0, B0, '0, 1'b0);
        run_scan(260, 20, 1000, 1000, B0, '0, '0, 1'b0);
        run_scan(270, 20, 1000, 1000, B0, B0, '0, 1'b0);

        repeat (3) @(posedge collClk);
        #1 chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coll_scan_engine.md
Name: coll_scan_engine

Overview:
- Parametrised, table-driven successor to the fixed-geometry collision logic.
- Holds N_OBJ rectangles in a loadable object table. On each start request it scans the table one object per clock against the Pac-Man and ghost sprites.
- Publishes per-object hit vectors for both players, plus a player-vs-player hit, atomically with a done pulse.
- Sits between the movement/game-state logic (which supplies positions, enables and start) and the score/maze-update logic.

Parameters:
- N_OBJ, 48, number of object table entries (walls and fruit); 1..64.
- IDX_W, 6, object index width; 2^IDX_W >= N_OBJ.
- COORD_W, 11, coordinate width for all x/y values.
- SPRITE, 50, sprite edge length in pixels (square sprites).

Ports:
- collClk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  scan request; accepted only in IDLE.
- x, y  in  COORD_W each  Pac-Man top-left; sampled when start is accepted.
- x_ghost, y_ghost  in  COORD_W each  ghost top-left; sampled when start is accepted.
- obj_en  in  N_OBJ  per-object enable; sampled when start is accepted.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  table entry to write.
- cfg_x0, cfg_y0, cfg_x1, cfg_y1  in  COORD_W each  rectangle corners; [x0,x1) by [y0,y1).
- busy  out  1  high while a scan is in progress, SCAN through DONE.
- done  out  1  one-cycle pulse; results valid and updated.
- hit_pac  out  N_OBJ  per-object Pac-Man hit.
- hit_ghost  out  N_OBJ  per-object ghost hit.
- player_hit  out  1  Pac-Man/ghost sprite overlap.

Behaviour:
- Reset:
  - State goes to IDLE.
  - busy, done, hit_pac, hit_ghost and player_hit all go to 0.
  - Every table entry goes to x0=y0=x1=y1=0; a degenerate rectangle never hits.
  - Captured positions and enables are cleared.
  - Reset mid-scan abandons the scan: no done pulse, outputs cleared.
- Overlap rule:
  - A sprite occupies [px, px+SPRITE) by [py, py+SPRITE).
  - A hit requires all of: px < x1, x0 < px+SPRITE, py < y1, y0 < py+SPRITE, and x1 > x0, y1 > y0.
  - Strict inequalities: touching edges do not collide.
  - All sums are evaluated at COORD_W+1 bits, so there is no wrap-around.
- Table writes:
  - If cfg_we=1 in IDLE and cfg_idx < N_OBJ, the entry is written at the clock edge.
  - A write with cfg_idx >= N_OBJ is ignored.
  - Writes while busy=1 are ignored.
  - A write in the same cycle as an accepted start lands before the scan begins.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: when start=1, capture x, y, x_ghost, y_ghost and obj_en; clear the internal shadow vectors; set idx=0; go to SCAN. Otherwise stay.
  - SCAN: evaluate entry idx for both sprites. Shadow bit = overlap AND captured obj_en[idx]. If idx = N_OBJ-1 go to DONE, else idx+1.
  - DONE:
    - Copy the shadow vectors to hit_pac/hit_ghost.
    - Set player_hit = overlap of the two captured sprite squares (same strict rule).
    - Pulse done=1 for this cycle; go to IDLE next cycle.
- Timing and output holding:
  - If start is accepted in cycle t, busy=1 in cycles t+1..t+N_OBJ+1 and done=1 in cycle t+N_OBJ+1.
  - The next start is accepted no earlier than t+N_OBJ+2.
- Outputs hold their values between scans. Input changes after capture do not affect the scan in progress.
- start while busy is ignored and is not queued.

Optional Feature:
- COLL_EDGE_EN defined:
  - Adds outputs new_hit_pac [N_OBJ] and new_hit_ghost [N_OBJ].
  - Each is valid only in the DONE cycle: (new result) AND NOT (previous published result); zero in all other cycles.
  - Reset clears the previous-result history, so the first scan reports every hit as new.
- COLL_EDGE_EN undefined: these ports and the history registers do not exist; all other behaviour is identical.

Test Plan:
- Common setup: N_OBJ=48. Load entry 0 = (310,25)-(330,65) with obj_en[0]=1.
- Pac-Man at (270,20), start: done at start+49; hit_pac[0]=1, all other bits 0.
- Pac-Man at (260,20), start: hit_pac[0]=0 (edge touch, 310 not < 310). Same position with obj_en[0]=0: also 0.
- Ghost at (320,40), Pac-Man at (300,60): hit_ghost[0]=1, hit_pac[0]=1, player_hit=1. Ghost moved to (400,200): player_hit=0.
- start pulsed again at start+10, and cfg_we to entry 1 mid-scan: neither takes effect; exactly one done pulse. Entry 1 remains all zeros with hit bit 0.
- rst asserted at start+20: busy=0 and no done pulse; all outputs 0; entry 0 cleared, so a rescan at (270,20) gives hit_pac[0]=0.
- COLL_EDGE_EN: two identical scans at (270,20): first scan new_hit_pac[0]=1, second 0. Move away then back: 1 again.
